// File: rtl/mux8_pkg.sv
// mux8_pkg: shared types and widths for the mux8 selector and its serializer
package mux8_pkg;
  typedef enum logic [0:0] {IDLE, SHIFT} ser_state_t;
  localparam int MUX_W = 8;
  localparam int SEL_W = 3;
endpackage

// File: rtl/mux8.sv
// mux8: eight-to-one bit selector
import mux8_pkg::*;
module mux8 (
  input  logic [SEL_W-1:0] s,
  input  logic [MUX_W-1:0] d,
  output logic             y
);
  assign y = d[s];
endmodule

// File: rtl/mux8_serializer.sv
// mux8_serializer: parallel-in, serial-out stage stepping mux8 through a held word
import mux8_pkg::*;
module mux8_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [MUX_W-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);
  ser_state_t       state_q;
  logic [SEL_W-1:0] cnt_q;
  logic [MUX_W-1:0] data_q;
  logic             ser_fire;
  logic             load_fire;
  assign ser_valid  = state_q == SHIFT;
  assign ser_last   = ser_valid & (cnt_q == 3'd7);
  assign busy       = ser_valid;
  assign ser_fire   = ser_valid & ser_ready;
  assign load_ready = !ser_valid | (ser_fire & ser_last);
  assign load_fire  = load_valid & load_ready;
  assign sel        = MSB_FIRST ? 3'd7 - cnt_q : cnt_q;
  mux8 u_mux (.s(sel), .d(data_q), .y(ser_bit));
  // Load a word when idle or on the final beat; otherwise advance one beat per accepted bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else if (load_fire) begin
      state_q <= SHIFT;
      cnt_q   <= '0;
      data_q  <= load_data;
    end else if (ser_fire) begin
      if (ser_last) state_q <= IDLE;
      else cnt_q <= cnt_q + 3'd1;
    end
  end
endmodule

// File: tb/tb_mux8_serializer.sv
// tb_mux8_serializer: directed checks of LSB-first and MSB-first serializer instances
module tb_mux8_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       ser_ready = 1'b0;
  logic       lr0, sv0, sb0, sl0, bz0, lr1, sv1, sb1, sl1, bz1;
  logic [2:0] sel0, sel1;
  int         checks = 0;
  int         failures = 0;
  mux8_serializer #(.MSB_FIRST(1'b0)) u0 (.clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr0),
    .load_data(load_data), .ser_valid(sv0), .ser_ready(ser_ready), .ser_bit(sb0), .ser_last(sl0), .sel(sel0), .busy(bz0));
  mux8_serializer #(.MSB_FIRST(1'b1)) u1 (.clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr1),
    .load_data(load_data), .ser_valid(sv1), .ser_ready(ser_ready), .ser_bit(sb1), .ser_last(sl1), .sel(sel1), .busy(bz1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag, input logic [2:0] s0, input logic [2:0] s1);
    #1;
    chk({tag, "_valid0"}, {7'd0, sv0}, 8'd0);
    chk({tag, "_valid1"}, {7'd0, sv1}, 8'd0);
    chk({tag, "_ready0"}, {7'd0, lr0}, 8'd1);
    chk({tag, "_ready1"}, {7'd0, lr1}, 8'd1);
    chk({tag, "_last"}, {6'd0, sl1, sl0}, 8'd0);
    chk({tag, "_busy"}, {6'd0, bz1, bz0}, 8'd0);
    chk({tag, "_sel0"}, {5'd0, sel0}, {5'd0, s0});
    chk({tag, "_sel1"}, {5'd0, sel1}, {5'd0, s1});
  endtask
  task automatic load(input logic [7:0] w, input bit keep);
    load_valid = 1'b1;
    load_data  = w;
    #1;
    chk("load_ready0", {7'd0, lr0}, 8'd1);
    chk("load_ready1", {7'd0, lr1}, 8'd1);
    tick();
    if (!keep) load_valid = 1'b0;
  endtask
  task automatic beat(input string tag, input logic [7:0] w, input int i);
    logic [2:0] k;
    k = 3'(i);
    #1;
    chk({tag, "_valid0"}, {7'd0, sv0}, 8'd1);
    chk({tag, "_busy1"}, {7'd0, bz1}, 8'd1);
    chk({tag, "_bit_lsb"}, {7'd0, sb0}, {7'd0, w[k]});
    chk({tag, "_bit_msb"}, {7'd0, sb1}, {7'd0, w[3'd7 - k]});
    chk({tag, "_sel_lsb"}, {5'd0, sel0}, {5'd0, k});
    chk({tag, "_sel_msb"}, {5'd0, sel1}, {5'd0, 3'd7 - k});
    chk({tag, "_last"}, {6'd0, sl1, sl0}, (i == 7) ? 8'd3 : 8'd0);
    chk({tag, "_lready"}, {6'd0, lr1, lr0}, (i == 7 && ser_ready) ? 8'd3 : 8'd0);
    tick();
  endtask
  initial begin
    #1;
    idle_chk("reset", 3'd0, 3'd7);
    chk("reset_bit", {6'd0, sb1, sb0}, 8'd0);
    tick();
    reset = 1'b0;
    ser_ready = 1'b1;
    load(8'hF0, 1'b0);
    for (int i = 0; i < 8; i++) beat("lsb_f0", 8'hF0, i);
    idle_chk("after_f0", 3'd7, 3'd0);
    load(8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) beat("msb_a5", 8'hA5, i);
    load(8'hF0, 1'b0);
    beat("bp", 8'hF0, 0);
    beat("bp", 8'hF0, 1);
    ser_ready = 1'b0;
    for (int j = 0; j < 3; j++) beat("bp_hold", 8'hF0, 2);
    ser_ready = 1'b1;
    for (int i = 2; i < 8; i++) beat("bp_resume", 8'hF0, i);
    load(8'h0F, 1'b1);
    load_data = 8'hF0;
    for (int i = 0; i < 8; i++) beat("b2b_0f", 8'h0F, i);
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) beat("b2b_f0", 8'hF0, i);
    idle_chk("after_b2b", 3'd7, 3'd0);
    load(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) beat("busy_00", 8'h00, i);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    beat("busy_offer", 8'h00, 3);
    beat("busy_offer", 8'h00, 4);
    load_valid = 1'b0;
    for (int i = 5; i < 8; i++) beat("busy_00", 8'h00, i);
    load(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) beat("pre_rst", 8'h5A, i);
    reset = 1'b1;
    idle_chk("mid_reset", 3'd0, 3'd7);
    chk("mid_reset_bit", {6'd0, sb1, sb0}, 8'd0);
    tick();
    reset = 1'b0;
    load(8'hC3, 1'b0);
    for (int i = 0; i < 8; i++) beat("post_rst", 8'hC3, i);
    idle_chk("end", 3'd7, 3'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
